// File: rtl/cellrv32_cpu_cp_shifter_iter_if.sv
// Request/response bundle between the CPU ALU and the iterative shift/rotate
// co-processor. The CPU side drives the request; the shifter answers on the
// OR-combined result bus.
interface cellrv32_cpu_cp_shifter_iter_if #(
    parameter int XLEN = 32
);
    localparam int SW = $clog2(XLEN);

    logic            start;  // single-cycle operation trigger
    logic            abort;  // abort on CPU trap
    logic [2:0]      op;     // 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR
    logic            word;   // 32-bit word op (RV64 *W)
    logic [XLEN-1:0] rs1;    // operand
    logic [SW-1:0]   shamt;  // shift amount
    logic [XLEN-1:0] res;    // result, zero unless valid
    logic            valid;  // result valid, one-cycle pulse
    logic            busy;   // operation in progress

    modport master (
        output start, abort, op, word, rs1, shamt,
        input  res, valid, busy
    );

    modport slave (
        input  start, abort, op, word, rs1, shamt,
        output res, valid, busy
    );
endinterface

// File: rtl/cellrv32_cpu_cp_shifter_iter.sv
// Iterative shift/rotate co-processor. Shifts STEP bits per cycle (bit-serial
// up to a single-pass barrel), supports Zbb rotates and, on RV64 with WORD_EN,
// the *W word ops via operand pre/post-processing around a common shift core.
module cellrv32_cpu_cp_shifter_iter #(
    parameter int XLEN    = 32,
    parameter int STEP    = 1,
    parameter int WORD_EN = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    cellrv32_cpu_cp_shifter_iter_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] sreg_q, sreg_d;
    logic [2:0]      op_q;
    logic            word_q;

    logic            word_act;   // word op requested and implemented
    logic [SW-1:0]   eff_shamt;  // shift amount after word masking
    logic [XLEN-1:0] pre_opnd;   // operand as loaded into the shift register
    logic [XLEN-1:0] post_res;   // shift register as presented on the bus
    logic [SW-1:0]   step_amt;   // bits moved this cycle: min(cnt, STEP)
    logic [SW-1:0]   rot_inv;    // XLEN - step_amt, modulo XLEN
    logic [XLEN-1:0] step_res;   // shift register after this cycle's step
    logic            accept;
    logic            done;

    if ((WORD_EN != 0) && (XLEN == 64)) begin : g_word
        // Word ops: mask the amount to 5 bits, shape the operand so the 64-bit
        // core produces the 32-bit answer in the low word, then sign-extend.
        always_comb begin
            word_act  = bus.word;
            eff_shamt = bus.word ? SW'(bus.shamt[4:0]) : bus.shamt;
            pre_opnd  = bus.rs1;
            if (bus.word) begin
                case (bus.op)
                    OP_SRL:         pre_opnd = {{(XLEN-32){1'b0}}, bus.rs1[31:0]};
                    OP_SRA:         pre_opnd = {{(XLEN-32){bus.rs1[31]}}, bus.rs1[31:0]};
                    OP_ROL, OP_ROR: pre_opnd = {bus.rs1[31:0], bus.rs1[31:0]};
                    default:        pre_opnd = bus.rs1;
                endcase
            end
            post_res = word_q ? {{(XLEN-32){sreg_q[31]}}, sreg_q[31:0]} : sreg_q;
        end
    end else begin : g_noword
        logic unused_word;

        assign word_act    = 1'b0;
        assign eff_shamt   = bus.shamt;
        assign pre_opnd    = bus.rs1;
        assign post_res    = sreg_q;
        assign unused_word = bus.word | word_q;
    end

    // Per-cycle step: move min(cnt, STEP) bits in the latched direction.
    always_comb begin
        if (int'(cnt_q) < STEP) begin
            step_amt = cnt_q;
        end else begin
            step_amt = SW'(STEP);
        end
        rot_inv = -step_amt;
        case (op_q)
            OP_SRL:  step_res = sreg_q >> step_amt;
            OP_SRA:  step_res = $unsigned($signed(sreg_q) >>> step_amt);
            OP_ROL:  step_res = (sreg_q << step_amt) | (sreg_q >> rot_inv);
            OP_ROR:  step_res = (sreg_q >> step_amt) | (sreg_q << rot_inv);
            default: step_res = sreg_q << step_amt;
        endcase
    end

    // Next-state and control: load on accepted start, step while cnt != 0,
    // report when cnt reaches zero; abort always wins.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    cnt_d   = eff_shamt;
                    sreg_d  = pre_opnd;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    sreg_d = step_res;
                    cnt_d  = cnt_q - step_amt;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, shift register and latched op/word flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments only, so every register samples the
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the datapath register is reset too, so nothing downstream
            // can ever observe an X from it.
            sreg_q  <= '0;
            op_q    <= OP_SLL;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            if (accept) begin
                op_q   <= bus.op;
                word_q <= word_act;
            end
        end
    end

    assign bus.valid = done;
    assign bus.busy  = (state_q == RUN);
    assign bus.res   = done ? post_res : '0;

endmodule
